mem_stage_fifo: RTL and testbench
=================================

Name: mem_stage_fifo

Overview:
Parametrised successor of the MEM pipeline stage. Completes the data-memory access for the instruction leaving EX by consuming the AXI read (R) or write-response (B) beat and aligning and extending load data. Holds up to BUF_DEPTH completed entries in an in-order output queue, replacing the fixed one-entry skid buffer. Sits between EX and WB, and generalises XLEN to 32 or 64.

Parameters:
XLEN, 32, datapath width; legal values 32 and 64.
BUF_DEPTH, 2, output queue entries including the head register; legal range 1..8.

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
valid_in  in  1  EX entry valid
ready_out  out  1  stage accepts the EX entry this cycle
flush_in  in  1  synchronous pipeline flush
flush_out  out  1  flush_in OR exc_taken_csr
valid_out  out  1  head entry valid toward WB
ready_in  in  1  WB accepts head
exc_taken_csr  in  1  CSR unit took a trap
PC_EX, IR_EX  in  32 each  instruction address and word
rd_wena_EX  in  1  register write; with wb_src_EX==SEL_MEM, 1=load, 0=store
rd_addr_EX  in  6  destination register (bit 5 selects FP file)
rd_data_EX  in  XLEN  ALU result
csr_rena_EX, csr_wena_EX  in  1 each  CSR access
wb_src_EX  in  3  writeback source select
mem_op_EX  in  3  load type from the CPU package
exc_pend_EX  in  1  exception already pending
exc_cause_EX  in  32  exception cause
dmem_axi_araddr  in  $clog2(XLEN/8)  low read address bits
dmem_axi_rdata  in  XLEN  read data
dmem_axi_rresp, dmem_axi_bresp  in  2 each  AXI responses
dmem_axi_rvalid, dmem_axi_bvalid  in  1 each
dmem_axi_rready, dmem_axi_bready  out  1 each
PC_MEM, IR_MEM, rd_wena_MEM, rd_addr_MEM, rd_data_MEM, csr_rena_MEM, csr_wena_MEM, wb_src_MEM, exc_pend_MEM, exc_cause_MEM  out  matching EX widths  head entry fields
occupancy  out  $clog2(BUF_DEPTH+1)  valid entries held

Behaviour:
- Reset or flush_in: all outputs and queue entries go to 0, and occupancy goes to 0. Reset is asynchronous; flush_in acts on the next clock edge.
- Queue is an in-order FIFO. The head drives the *_MEM outputs, and valid_out = occupancy != 0.
- Pop when valid_out && ready_in.
- Push when valid_in && ready_out. Simultaneous push and pop is allowed at any occupancy, including full.
- ready_out = !stall && (occupancy < BUF_DEPTH || (valid_out && ready_in)).
- stall is asserted when any of the following holds:
  - flush_out
  - any queued entry has exc_pend, csr_rena or csr_wena set (serialising)
  - !exc_pend_EX && wb_src_EX==SEL_MEM && the required response is not valid: rvalid for a load, bvalid for a store.
- rready = load && valid_in && ready_out; bready = store && valid_in && ready_out. Each is set only in the cycle that consumes the beat.
- Load data is rdata >> (8*araddr), then sign- or zero-extended to XLEN per mem_op:
  - LB, LBU, LH, LHU, LW, LWU: extend from the access size.
  - LD is legal only for XLEN=64. With XLEN=32, LD is treated as LW.
- A nonzero rresp or bresp on the consumed beat sets the pushed entry's exc_pend=1 and exc_cause=CAUSE_DMEM_BUS_ERROR. rd_data keeps the ALU value in that case.
- An entry with exc_pend_EX=1 does not wait for or consume any AXI beat.
- Latency: an entry pushed at edge N appears on valid_out after edge N when the queue was empty.
- A push into a full queue with a simultaneous pop places the new entry at the tail; order is preserved.
- Pointers wrap modulo BUF_DEPTH, and BUF_DEPTH need not be a power of two.

Optional Feature:
MEM_STAGE_PERF_EN:
- When defined: adds output port wait_cycles (32 bits). It increments on every cycle where valid_in && !exc_pend_EX && wb_src_EX==SEL_MEM && no response is valid. It saturates at 0xFFFFFFFF and is cleared by reset only, not by flush.
- When undefined: the port and the counter are absent.

Decomposition:
- CPU_pkg receives:
  - MEM_LWU and MEM_LD encodings
  - a mem_entry_t packed struct holding all *_MEM fields, parametrised via XLEN-max width 64 and truncated in the stage
  - CAUSE_DMEM_BUS_ERROR, which already exists
- One sub-module, mem_load_align: a combinational shift plus extend, parametrised on XLEN.

Test Plan:
- Load, XLEN=32, LB with araddr=3 and rdata=0x80FF_FF00 -> rd_data_MEM=0xFFFF_FF80, with rready pulsed for exactly 1 cycle.
- Store with bresp=2'b10 -> exc_pend_MEM=1, exc_cause_MEM=CAUSE_DMEM_BUS_ERROR, and no further pushes until the entry pops.
- BUF_DEPTH=3, ready_in=0, 3 ALU entries pushed -> occupancy=3 and ready_out=0. Then ready_in=1 while valid_in=1 -> push and pop in the same cycle, FIFO order kept, occupancy stays 3.
- Load with rvalid held low for 4 cycles -> ready_out=0 for those 4 cycles, and wait_cycles=4 when MEM_STAGE_PERF_EN is defined.
- flush_in while occupancy=2 and a load beat is valid -> next cycle occupancy=0, valid_out=0, and rready was 0 during the flush.
- XLEN=64, LD with araddr=0 and rdata=0x0123_4567_89AB_CDEF -> identical rd_data_MEM; LWU with araddr=4 -> 0x0000_0000_0123_4567.

Source files
------------

// File: rtl/mem_stage_fifo_pkg.sv
// rtl/mem_stage_fifo_pkg.sv - shared encodings and queue entry type for the MEM stage
// Purpose: writeback-source and load-type encodings, the data-memory bus error
//          cause, and the packed queue entry. rd_data is carried at the maximum
//          datapath width (64) and truncated to XLEN by the stage.
// Ports:   none (package)
package mem_stage_fifo_pkg;

  localparam int unsigned MAX_XLEN = 64;

  // Writeback source select
  localparam logic [2:0] SEL_ALU = 3'd0;
  localparam logic [2:0] SEL_MEM = 3'd1;
  localparam logic [2:0] SEL_CSR = 3'd2;
  localparam logic [2:0] SEL_PC4 = 3'd3;

  // Load types (funct3-style encoding)
  localparam logic [2:0] MEM_LB  = 3'd0;
  localparam logic [2:0] MEM_LH  = 3'd1;
  localparam logic [2:0] MEM_LW  = 3'd2;
  localparam logic [2:0] MEM_LD  = 3'd3;
  localparam logic [2:0] MEM_LBU = 3'd4;
  localparam logic [2:0] MEM_LHU = 3'd5;
  localparam logic [2:0] MEM_LWU = 3'd6;

  localparam logic [31:0] CAUSE_DMEM_BUS_ERROR = 32'd5;

  typedef struct packed {
    logic [31:0]         pc;
    logic [31:0]         ir;
    logic                rd_wena;
    logic [5:0]          rd_addr;
    logic [MAX_XLEN-1:0] rd_data;
    logic                csr_rena;
    logic                csr_wena;
    logic [2:0]          wb_src;
    logic                exc_pend;
    logic [31:0]         exc_cause;
  } mem_entry_t;

endpackage

// File: rtl/mem_stage_fifo_load_align.sv
// rtl/mem_stage_fifo_load_align.sv - load data byte alignment and sign/zero extension
// Purpose: shifts the read beat right by the byte offset, then extends from the
//          access size given by the load type. LD on a 32-bit datapath is a LW.
// Ports:   rdata_i (XLEN) read beat, off_i byte offset, op_i load type,
//          data_o (XLEN) aligned and extended result.
module mem_load_align #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]           rdata_i,
  input  logic [$clog2(XLEN/8)-1:0] off_i,
  input  logic [2:0]                op_i,
  output logic [XLEN-1:0]           data_o
);
  import mem_stage_fifo_pkg::*;

  logic [XLEN-1:0] shifted;

  assign shifted = rdata_i >> {off_i, 3'b000};

  // Size casts of signed slices sign-extend; unsigned slices zero-extend.
  always_comb begin
    data_o = shifted;
    case (op_i)
      MEM_LB:  data_o = XLEN'($signed(shifted[7:0]));
      MEM_LBU: data_o = XLEN'(shifted[7:0]);
      MEM_LH:  data_o = XLEN'($signed(shifted[15:0]));
      MEM_LHU: data_o = XLEN'(shifted[15:0]);
      MEM_LW:  data_o = XLEN'($signed(shifted[31:0]));
      MEM_LWU: data_o = XLEN'(shifted[31:0]);
      MEM_LD:  data_o = (XLEN == 64) ? shifted : XLEN'($signed(shifted[31:0]));
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_fifo.sv
// rtl/mem_stage_fifo.sv - MEM pipeline stage with an in-order output queue
// Purpose: completes the data-memory access of the EX entry by consuming the
//          AXI R or B beat, aligns load data, and holds up to BUF_DEPTH
//          completed entries toward WB.
// Ports:   clk/reset (async, active-high); EX side valid_in/ready_out and
//          *_EX fields; AXI R/B response inputs with rready/bready; WB side
//          valid_out/ready_in and head-entry *_MEM fields; flush_in/flush_out;
//          occupancy = entries held.
// Option:  MEM_STAGE_PERF_EN adds wait_cycles, a saturating count of cycles an
//          EX memory access waited on a response (cleared by reset only).
module mem_stage_fifo
  import mem_stage_fifo_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           valid_in,
  output logic                           ready_out,
  input  logic                           flush_in,
  output logic                           flush_out,
  output logic                           valid_out,
  input  logic                           ready_in,
  input  logic                           exc_taken_csr,
  input  logic [31:0]                    PC_EX,
  input  logic [31:0]                    IR_EX,
  input  logic                           rd_wena_EX,
  input  logic [5:0]                     rd_addr_EX,
  input  logic [XLEN-1:0]                rd_data_EX,
  input  logic                           csr_rena_EX,
  input  logic                           csr_wena_EX,
  input  logic [2:0]                     wb_src_EX,
  input  logic [2:0]                     mem_op_EX,
  input  logic                           exc_pend_EX,
  input  logic [31:0]                    exc_cause_EX,
  input  logic [$clog2(XLEN/8)-1:0]      dmem_axi_araddr,
  input  logic [XLEN-1:0]                dmem_axi_rdata,
  input  logic [1:0]                     dmem_axi_rresp,
  input  logic [1:0]                     dmem_axi_bresp,
  input  logic                           dmem_axi_rvalid,
  input  logic                           dmem_axi_bvalid,
  output logic                           dmem_axi_rready,
  output logic                           dmem_axi_bready,
  output logic [31:0]                    PC_MEM,
  output logic [31:0]                    IR_MEM,
  output logic                           rd_wena_MEM,
  output logic [5:0]                     rd_addr_MEM,
  output logic [XLEN-1:0]                rd_data_MEM,
  output logic                           csr_rena_MEM,
  output logic                           csr_wena_MEM,
  output logic [2:0]                     wb_src_MEM,
  output logic                           exc_pend_MEM,
  output logic [31:0]                    exc_cause_MEM,
  output logic [$clog2(BUF_DEPTH+1)-1:0] occupancy
`ifdef MEM_STAGE_PERF_EN
  ,
  output logic [31:0]                    wait_cycles
`endif
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);

  mem_entry_t       buf_q [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  mem_entry_t       head, push_entry;
  logic [XLEN-1:0]  load_data;
  logic             mem_access, resp_valid, bus_err, serialise, stall, push, pop;
  logic             unused_rd_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  mem_load_align #(.XLEN(XLEN)) u_align (
    .rdata_i (dmem_axi_rdata),
    .off_i   (dmem_axi_araddr),
    .op_i    (mem_op_EX),
    .data_o  (load_data)
  );

  // Entries already carrying an exception never touch the bus.
  assign mem_access = !exc_pend_EX && (wb_src_EX == SEL_MEM);
  assign resp_valid = rd_wena_EX ? dmem_axi_rvalid : dmem_axi_bvalid;
  assign bus_err    = mem_access && (rd_wena_EX ? (dmem_axi_rresp != 2'b00)
                                                : (dmem_axi_bresp != 2'b00));

  // Popped slots are cleared, so empty slots never contribute here.
  always_comb begin
    serialise = 1'b0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      serialise = serialise | buf_q[i].exc_pend | buf_q[i].csr_rena | buf_q[i].csr_wena;
    end
  end

  assign flush_out       = flush_in | exc_taken_csr;
  assign valid_out       = (occ_q != '0);
  assign stall           = flush_out || serialise || (mem_access && !resp_valid);
  assign pop             = valid_out && ready_in;
  assign ready_out       = !stall && ((occ_q < OCC_W'(BUF_DEPTH)) || pop);
  assign push            = valid_in && ready_out;
  assign dmem_axi_rready = push && mem_access && rd_wena_EX;
  assign dmem_axi_bready = push && mem_access && !rd_wena_EX;

  always_comb begin
    push_entry          = '0;
    push_entry.pc       = PC_EX;
    push_entry.ir       = IR_EX;
    push_entry.rd_wena  = rd_wena_EX;
    push_entry.rd_addr  = rd_addr_EX;
    push_entry.rd_data  = (mem_access && rd_wena_EX && !bus_err) ? MAX_XLEN'(load_data)
                                                                 : MAX_XLEN'(rd_data_EX);
    push_entry.csr_rena = csr_rena_EX;
    push_entry.csr_wena = csr_wena_EX;
    push_entry.wb_src   = wb_src_EX;
    push_entry.exc_pend = exc_pend_EX | bus_err;
    push_entry.exc_cause = bus_err ? CAUSE_DMEM_BUS_ERROR : exc_cause_EX;
  end

  always_comb begin
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else if (flush_in) begin
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      // On full push+pop the pointers coincide; the later write wins.
      if (pop)  buf_q[rd_ptr_q] <= '0;
      if (push) buf_q[wr_ptr_q] <= push_entry;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign head           = buf_q[rd_ptr_q];
  assign PC_MEM         = head.pc;
  assign IR_MEM         = head.ir;
  assign rd_wena_MEM    = head.rd_wena;
  assign rd_addr_MEM    = head.rd_addr;
  assign rd_data_MEM    = head.rd_data[XLEN-1:0];
  assign csr_rena_MEM   = head.csr_rena;
  assign csr_wena_MEM   = head.csr_wena;
  assign wb_src_MEM     = head.wb_src;
  assign exc_pend_MEM   = head.exc_pend;
  assign exc_cause_MEM  = head.exc_cause;
  assign occupancy      = occ_q;
  assign unused_rd_data = ^head.rd_data;

`ifdef MEM_STAGE_PERF_EN
  logic [31:0] wait_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q <= '0;
    end else if (valid_in && mem_access && !dmem_axi_rvalid && !dmem_axi_bvalid
                 && (wait_q != 32'hFFFF_FFFF)) begin
      wait_q <= wait_q + 32'd1;
    end
  end

  assign wait_cycles = wait_q;
`endif

endmodule

// File: tb/tb_mem_stage_fifo.sv
// tb/tb_mem_stage_fifo.sv - scoreboard bench for mem_stage_fifo (XLEN=64, BUF_DEPTH=3)
module tb_mem_stage_fifo;
  import mem_stage_fifo_pkg::*;

  localparam int XLEN = 64;
  localparam int BUF_DEPTH = 3;

  logic clk = 1'b0;
  logic reset;
  logic valid_in, ready_out, flush_in, flush_out, valid_out, ready_in, exc_taken_csr;
  logic [31:0] PC_EX, IR_EX, exc_cause_EX;
  logic rd_wena_EX, csr_rena_EX, csr_wena_EX, exc_pend_EX;
  logic [5:0] rd_addr_EX;
  logic [XLEN-1:0] rd_data_EX;
  logic [2:0] wb_src_EX, mem_op_EX;
  logic [2:0] dmem_axi_araddr;
  logic [XLEN-1:0] dmem_axi_rdata;
  logic [1:0] dmem_axi_rresp, dmem_axi_bresp;
  logic dmem_axi_rvalid, dmem_axi_bvalid, dmem_axi_rready, dmem_axi_bready;
  logic [31:0] PC_MEM, IR_MEM, exc_cause_MEM;
  logic rd_wena_MEM, csr_rena_MEM, csr_wena_MEM, exc_pend_MEM;
  logic [5:0] rd_addr_MEM;
  logic [XLEN-1:0] rd_data_MEM;
  logic [2:0] wb_src_MEM;
  logic [1:0] occupancy;
`ifdef MEM_STAGE_PERF_EN
  logic [31:0] wait_cycles;
  logic [31:0] exp_wait = 32'd0;
`endif

  mem_stage_fifo #(.XLEN(XLEN), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
    .flush_in(flush_in), .flush_out(flush_out), .valid_out(valid_out), .ready_in(ready_in),
    .exc_taken_csr(exc_taken_csr), .PC_EX(PC_EX), .IR_EX(IR_EX), .rd_wena_EX(rd_wena_EX),
    .rd_addr_EX(rd_addr_EX), .rd_data_EX(rd_data_EX), .csr_rena_EX(csr_rena_EX),
    .csr_wena_EX(csr_wena_EX), .wb_src_EX(wb_src_EX), .mem_op_EX(mem_op_EX),
    .exc_pend_EX(exc_pend_EX), .exc_cause_EX(exc_cause_EX),
    .dmem_axi_araddr(dmem_axi_araddr), .dmem_axi_rdata(dmem_axi_rdata),
    .dmem_axi_rresp(dmem_axi_rresp), .dmem_axi_bresp(dmem_axi_bresp),
    .dmem_axi_rvalid(dmem_axi_rvalid), .dmem_axi_bvalid(dmem_axi_bvalid),
    .dmem_axi_rready(dmem_axi_rready), .dmem_axi_bready(dmem_axi_bready),
    .PC_MEM(PC_MEM), .IR_MEM(IR_MEM), .rd_wena_MEM(rd_wena_MEM), .rd_addr_MEM(rd_addr_MEM),
    .rd_data_MEM(rd_data_MEM), .csr_rena_MEM(csr_rena_MEM), .csr_wena_MEM(csr_wena_MEM),
    .wb_src_MEM(wb_src_MEM), .exc_pend_MEM(exc_pend_MEM), .exc_cause_MEM(exc_cause_MEM),
    .occupancy(occupancy)
`ifdef MEM_STAGE_PERF_EN
    , .wait_cycles(wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  mem_entry_t exp_q[$];
  logic s_ready, s_rready, s_bready;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference load result: shift by byte offset, mask to access size, extend.
  function automatic logic [63:0] model_load(input logic [63:0] rdata, input int off,
                                             input logic [2:0] op);
    logic [63:0] v, mask;
    int bytes;
    bit sgn;
    v = rdata >> (8 * off);
    case (op)
      MEM_LB:  begin bytes = 1; sgn = 1; end
      MEM_LBU: begin bytes = 1; sgn = 0; end
      MEM_LH:  begin bytes = 2; sgn = 1; end
      MEM_LHU: begin bytes = 2; sgn = 0; end
      MEM_LW:  begin bytes = 4; sgn = 1; end
      MEM_LWU: begin bytes = 4; sgn = 0; end
      default: begin bytes = 8; sgn = 0; end
    endcase
    if (bytes < 8) begin
      mask = (64'd1 << (8 * bytes)) - 64'd1;
      v = v & mask;
      if (sgn && v[8 * bytes - 1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic idle();
    valid_in = 0; flush_in = 0; exc_taken_csr = 0; ready_in = 1;
    PC_EX = 0; IR_EX = 0; rd_wena_EX = 0; rd_addr_EX = 0; rd_data_EX = 0;
    csr_rena_EX = 0; csr_wena_EX = 0; wb_src_EX = SEL_ALU; mem_op_EX = MEM_LW;
    exc_pend_EX = 0; exc_cause_EX = 0; dmem_axi_araddr = 0; dmem_axi_rdata = 0;
    dmem_axi_rresp = 0; dmem_axi_bresp = 0; dmem_axi_rvalid = 0; dmem_axi_bvalid = 0;
  endtask

  task automatic alu(input logic [31:0] pc);
    idle();
    valid_in = 1; PC_EX = pc; IR_EX = ~pc; rd_wena_EX = 1;
    rd_addr_EX = pc[5:0]; rd_data_EX = {pc, pc};
  endtask

  task automatic load(input logic [2:0] op, input logic [2:0] off, input logic [63:0] data);
    idle();
    valid_in = 1; PC_EX = 32'h400; IR_EX = 32'h3; rd_wena_EX = 1; rd_addr_EX = 6'd7;
    rd_data_EX = 64'hAAAA; wb_src_EX = SEL_MEM; mem_op_EX = op;
    dmem_axi_araddr = off; dmem_axi_rdata = data; dmem_axi_rvalid = 1;
  endtask

  task automatic rand_inputs();
    logic [2:0] others [3];
    others[0] = SEL_ALU; others[1] = SEL_CSR; others[2] = SEL_PC4;
    valid_in = ($urandom % 4) != 0;
    flush_in = ($urandom % 40) == 0;
    exc_taken_csr = ($urandom % 50) == 0;
    ready_in = ($urandom % 4) != 0;
    PC_EX = $urandom; IR_EX = $urandom;
    rd_wena_EX = $urandom % 2; rd_addr_EX = 6'($urandom);
    rd_data_EX = {$urandom, $urandom};
    csr_rena_EX = ($urandom % 12) == 0; csr_wena_EX = ($urandom % 12) == 0;
    wb_src_EX = ($urandom % 2) ? SEL_MEM : others[$urandom % 3];
    mem_op_EX = 3'($urandom % 7);
    exc_pend_EX = ($urandom % 10) == 0; exc_cause_EX = $urandom;
    dmem_axi_araddr = 3'($urandom); dmem_axi_rdata = {$urandom, $urandom};
    dmem_axi_rresp = (($urandom % 8) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    dmem_axi_bresp = (($urandom % 8) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    dmem_axi_rvalid = ($urandom % 3) != 0; dmem_axi_bvalid = ($urandom % 3) != 0;
  endtask

  // Called at a negedge with inputs applied; checks handshake outputs against
  // the queue model, records the expected entry on push, returns at next negedge.
  task automatic cycle();
    int sz;
    bit serial, mem, resp, fl, e_ready, e_push, err;
    mem_entry_t e;
    #1;
    sz = exp_q.size();
    serial = 0;
    foreach (exp_q[i]) serial |= exp_q[i].exc_pend | exp_q[i].csr_rena | exp_q[i].csr_wena;
    mem = (wb_src_EX == SEL_MEM) && !exc_pend_EX;
    resp = rd_wena_EX ? dmem_axi_rvalid : dmem_axi_bvalid;
    fl = flush_in || exc_taken_csr;
    e_ready = !fl && !serial && !(mem && !resp) && (sz < BUF_DEPTH || (sz != 0 && ready_in));
    e_push = valid_in && e_ready;
    chk("ready_out", 64'(ready_out), 64'(e_ready));
    chk("rready", 64'(dmem_axi_rready), 64'(e_push && mem && rd_wena_EX));
    chk("bready", 64'(dmem_axi_bready), 64'(e_push && mem && !rd_wena_EX));
    chk("valid_out", 64'(valid_out), 64'(sz != 0));
    chk("occupancy", 64'(occupancy), 64'(sz));
    chk("flush_out", 64'(flush_out), 64'(fl));
`ifdef MEM_STAGE_PERF_EN
    chk("wait_cycles", 64'(wait_cycles), 64'(exp_wait));
    if (valid_in && mem && !dmem_axi_rvalid && !dmem_axi_bvalid && exp_wait != 32'hFFFF_FFFF)
      exp_wait++;
`endif
    s_ready = ready_out; s_rready = dmem_axi_rready; s_bready = dmem_axi_bready;
    if (flush_in) begin
      exp_q.delete();
    end else if (e_push) begin
      err = mem && (rd_wena_EX ? dmem_axi_rresp != 0 : dmem_axi_bresp != 0);
      e = '0;
      e.pc = PC_EX; e.ir = IR_EX; e.rd_wena = rd_wena_EX; e.rd_addr = rd_addr_EX;
      e.csr_rena = csr_rena_EX; e.csr_wena = csr_wena_EX; e.wb_src = wb_src_EX;
      e.exc_pend = exc_pend_EX || err;
      e.exc_cause = err ? CAUSE_DMEM_BUS_ERROR : exc_cause_EX;
      e.rd_data = (mem && rd_wena_EX && !err)
                  ? model_load(dmem_axi_rdata, int'(dmem_axi_araddr), mem_op_EX) : rd_data_EX;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    idle();
    repeat (5) cycle();
  endtask

  // Monitor: on every WB handshake, pop the oldest expected entry and compare.
  initial begin
    mem_entry_t act, exp;
    forever begin
      @(negedge clk);
      #3;
      if (!reset && !flush_in && valid_out && ready_in) begin
        act = '0;
        act.pc = PC_MEM; act.ir = IR_MEM; act.rd_wena = rd_wena_MEM; act.rd_addr = rd_addr_MEM;
        act.rd_data = rd_data_MEM; act.csr_rena = csr_rena_MEM; act.csr_wena = csr_wena_MEM;
        act.wb_src = wb_src_MEM; act.exc_pend = exc_pend_MEM; act.exc_cause = exc_cause_MEM;
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL head_entry: got unexpected entry %h expected none", act);
        end else begin
          exp = exp_q.pop_front();
          if (act === exp) n_pass++;
          else $display("FAIL head_entry: got %h expected %h", act, exp);
        end
      end
    end
  end

  initial begin
    idle();
    reset = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_valid_out", 64'(valid_out), 64'd0);
    chk("reset_occupancy", 64'(occupancy), 64'd0);
    chk("reset_pc", 64'(PC_MEM), 64'd0);
    chk("reset_rd_data", rd_data_MEM, 64'd0);
    chk("reset_exc_pend", 64'(exc_pend_MEM), 64'd0);
    chk("reset_rready", 64'(dmem_axi_rready), 64'd0);
    @(negedge clk);
    reset = 0;

    // LB at byte 3: 0x80 sign-extended; rready pulses exactly once
    load(MEM_LB, 3'd3, 64'h80FF_FF00); ready_in = 0;
    cycle();
    chk("lb_rready_pulse", 64'(s_rready), 64'd1);
    chk("lb_data", rd_data_MEM, 64'hFFFF_FFFF_FFFF_FF80);
    idle(); ready_in = 0;
    cycle();
    chk("lb_rready_once", 64'(s_rready), 64'd0);
    drain();

    // Store with SLVERR: exception entry serialises until it pops
    idle(); valid_in = 1; PC_EX = 32'h500; wb_src_EX = SEL_MEM; rd_wena_EX = 0;
    dmem_axi_bvalid = 1; dmem_axi_bresp = 2'b10; ready_in = 0;
    cycle();
    chk("st_bready", 64'(s_bready), 64'd1);
    chk("st_exc_pend", 64'(exc_pend_MEM), 64'd1);
    chk("st_exc_cause", 64'(exc_cause_MEM), 64'(CAUSE_DMEM_BUS_ERROR));
    for (int i = 0; i < 2; i++) begin
      alu(32'h300); ready_in = 0;
      cycle();
      chk("st_block", 64'(s_ready), 64'd0);
    end
    alu(32'h300);
    cycle();
    chk("st_block_pop", 64'(s_ready), 64'd0);
    alu(32'h300);
    cycle();
    chk("st_unblock", 64'(s_ready), 64'd1);
    drain();

    // Fill to depth, then push+pop while full keeps order and occupancy
    for (int i = 0; i < 3; i++) begin
      alu(32'h100 + 32'(4 * i)); ready_in = 0;
      cycle();
    end
    alu(32'h10C); ready_in = 0;
    cycle();
    chk("full_ready", 64'(s_ready), 64'd0);
    chk("full_occ", 64'(occupancy), 64'd3);
    alu(32'h10C); ready_in = 1;
    cycle();
    chk("full_pushpop_ready", 64'(s_ready), 64'd1);
    chk("full_pushpop_occ", 64'(occupancy), 64'd3);
    chk("full_pushpop_head", 64'(PC_MEM), 64'h104);
    drain();

    // Load waiting four cycles on rvalid
    for (int i = 0; i < 4; i++) begin
      load(MEM_LW, 3'd0, 64'h1234_5678); dmem_axi_rvalid = 0;
      cycle();
      chk("wait_ready", 64'(s_ready), 64'd0);
    end
`ifdef MEM_STAGE_PERF_EN
    chk("wait_count", 64'(wait_cycles), 64'd4);
`endif
    load(MEM_LW, 3'd0, 64'h1234_5678);
    cycle();
    chk("wait_accept", 64'(s_ready), 64'd1);
    drain();

    // Flush with two entries held and a load beat offered
    alu(32'h200); ready_in = 0; cycle();
    alu(32'h204); ready_in = 0; cycle();
    load(MEM_LW, 3'd0, 64'h55); ready_in = 0; flush_in = 1;
    cycle();
    chk("flush_rready", 64'(s_rready), 64'd0);
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_valid", 64'(valid_out), 64'd0);
    drain();

    // 64-bit loads
    load(MEM_LD, 3'd0, 64'h0123_4567_89AB_CDEF); ready_in = 0;
    cycle();
    chk("ld_data", rd_data_MEM, 64'h0123_4567_89AB_CDEF);
    drain();
    load(MEM_LWU, 3'd4, 64'h0123_4567_89AB_CDEF); ready_in = 0;
    cycle();
    chk("lwu_data", rd_data_MEM, 64'h0000_0000_0123_4567);
    drain();

    // Randomised traffic against the queue model
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      cycle();
    end
    drain();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
